// File: rtl/alp_fcon_fgate.sv
// ---------------------------------------------------------------------------
// alp_fcon_fgate
// Per-stream frame gate on the HPDF side of frame control. A rising edge of
// i_vsync starts a frame: a one-cycle o_fcon_fstart pulse goes out to fcon,
// and MASK_LAT cycles later the returned i_fcon_mask is sampled to decide
// whether the whole frame passes or is dropped. The pixel stream is delayed
// by MASK_LAT+2 cycles so the new decision applies from the frame's first
// cycle.
//
// Ports
//   i_clk, i_rstn        clock, synchronous active-low reset
//   i_enable             1: mask gating active, 0: every frame passes
//   i_cnt_clr            synchronous clear of both counters and o_err
//   i_vsync/i_pvalid/i_pdata   incoming stream
//   o_fcon_fstart        frame-start pulse to fcon
//   i_fcon_mask          mask returned by fcon (1 = drop frame)
//   o_vsync/o_pvalid/o_pdata   gated, delayed stream (data 0 when gated)
//   o_frame_drop         one-cycle pulse when a frame is decided "drop"
//   o_err                sticky: vsync rise while a decision is pending
//   o_pass_cnt/o_drop_cnt  saturating frame counters
// ---------------------------------------------------------------------------
module alp_fcon_fgate #(
    parameter int DW       = 32,
    parameter int MASK_LAT = 4,
    parameter int CW       = 16
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_enable,
    input  logic          i_cnt_clr,
    input  logic          i_vsync,
    input  logic          i_pvalid,
    input  logic [DW-1:0] i_pdata,
    output logic          o_fcon_fstart,
    input  logic          i_fcon_mask,
    output logic          o_vsync,
    output logic          o_pvalid,
    output logic [DW-1:0] o_pdata,
    output logic          o_frame_drop,
    output logic          o_err,
    output logic [CW-1:0] o_pass_cnt,
    output logic [CW-1:0] o_drop_cnt
);

    localparam int LW = (MASK_LAT < 1) ? 1 : $clog2(MASK_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic            vsync_prev_q;
    logic            en_q, en_d;
    logic            gate_q, gate_d;
    logic            fstart_q, fstart_d;
    logic            fdrop_q, fdrop_d;
    logic            err_q, err_d;
    logic [CW-1:0]   pass_q, pass_d;
    logic [CW-1:0]   dcnt_q, dcnt_d;

    // Delay line: MASK_LAT+1 internal stages; the output register is the last stage.
    logic [MASK_LAT:0] vs_pipe_q;
    logic [MASK_LAT:0] pv_pipe_q;
    logic [DW-1:0]     pd_pipe_q [MASK_LAT+1];

    logic            ovs_q, ovs_d;
    logic            opv_q, opv_d;
    logic [DW-1:0]   opd_q, opd_d;

    logic            rise_s;
    logic            sample_s;
    logic            drop_s;

    // Frame FSM, decision, counters and output stage next-state logic.
    always_comb begin
        state_d  = state_q;
        lat_d    = lat_q;
        en_d     = en_q;
        gate_d   = gate_q;
        fstart_d = 1'b0;
        fdrop_d  = 1'b0;
        err_d    = err_q;
        pass_d   = pass_q;
        dcnt_d   = dcnt_q;
        sample_s = 1'b0;
        drop_s   = 1'b0;
        rise_s   = i_vsync & ~vsync_prev_q;

        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    state_d  = ST_WAIT;
                    lat_d    = LW'(MASK_LAT);
                    en_d     = i_enable;
                    fstart_d = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (lat_q == {LW{1'b0}}) begin
                    sample_s = 1'b1;
                    drop_s   = en_q & i_fcon_mask;
                    gate_d   = ~drop_s;
                    fdrop_d  = drop_s;
                    // A frame that already ended still receives its decision.
                    state_d  = i_vsync ? ST_ACTIVE : ST_IDLE;
                end else begin
                    lat_d    = lat_q - LW'(1);
                end
            end
            ST_ACTIVE: begin
                if (!i_vsync) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A rise during WAIT wins over a coincident clear so the error is not lost.
        if (rise_s && (state_q == ST_WAIT)) begin
            err_d = 1'b1;
        end else if (i_cnt_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        if (sample_s && drop_s && (dcnt_q != {CW{1'b1}})) begin
            dcnt_d = dcnt_q + CW'(1);
        end else begin
            dcnt_d = dcnt_q;
        end
        if (sample_s && !drop_s && (pass_q != {CW{1'b1}})) begin
            pass_d = pass_q + CW'(1);
        end else begin
            pass_d = pass_q;
        end
        if (i_cnt_clr) begin
            pass_d = {CW{1'b0}};
            dcnt_d = {CW{1'b0}};
        end else begin
            pass_d = pass_d;
            dcnt_d = dcnt_d;
        end

        // Output stage uses the next gate so the decision lands on the frame's first cycle.
        ovs_d = vs_pipe_q[MASK_LAT] & gate_d;
        opv_d = pv_pipe_q[MASK_LAT] & gate_d;
        if (gate_d) begin
            opd_d = pd_pipe_q[MASK_LAT];
        end else begin
            opd_d = {DW{1'b0}};
        end
    end

    // Control, counter and output registers.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q      <= ST_IDLE;
            lat_q        <= {LW{1'b0}};
            vsync_prev_q <= 1'b1;   // a frame already in progress never triggers fstart
            en_q         <= 1'b0;
            gate_q       <= 1'b0;
            fstart_q     <= 1'b0;
            fdrop_q      <= 1'b0;
            err_q        <= 1'b0;
            pass_q       <= {CW{1'b0}};
            dcnt_q       <= {CW{1'b0}};
            ovs_q        <= 1'b0;
            opv_q        <= 1'b0;
            opd_q        <= {DW{1'b0}};
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            vsync_prev_q <= i_vsync;
            en_q         <= en_d;
            gate_q       <= gate_d;
            fstart_q     <= fstart_d;
            fdrop_q      <= fdrop_d;
            err_q        <= err_d;
            pass_q       <= pass_d;
            dcnt_q       <= dcnt_d;
            ovs_q        <= ovs_d;
            opv_q        <= opv_d;
            opd_q        <= opd_d;
        end
    end

    // Stream delay line, flushed on reset.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            vs_pipe_q <= {(MASK_LAT+1){1'b0}};
            pv_pipe_q <= {(MASK_LAT+1){1'b0}};
            for (int k = 0; k <= MASK_LAT; k++) begin
                pd_pipe_q[k] <= {DW{1'b0}};
            end
        end else begin
            vs_pipe_q    <= {vs_pipe_q[MASK_LAT-1:0], i_vsync};
            pv_pipe_q    <= {pv_pipe_q[MASK_LAT-1:0], i_pvalid};
            pd_pipe_q[0] <= i_pdata;
            for (int k = 1; k <= MASK_LAT; k++) begin
                pd_pipe_q[k] <= pd_pipe_q[k-1];
            end
        end
    end

    assign o_fcon_fstart = fstart_q;
    assign o_frame_drop  = fdrop_q;
    assign o_err         = err_q;
    assign o_pass_cnt    = pass_q;
    assign o_drop_cnt    = dcnt_q;
    assign o_vsync       = ovs_q;
    assign o_pvalid      = opv_q;
    assign o_pdata       = opd_q;

endmodule

// File: tb/tb_alp_fcon_fgate.sv
// ---------------------------------------------------------------------------
// tb_alp_fcon_fgate
// Drives directed frame scenarios and randomized frames into alp_fcon_fgate
// and compares every output on every cycle against a cycle-indexed model of
// the frame-gate rules. Counter width is reduced so saturation is reachable.
// ---------------------------------------------------------------------------
module tb_alp_fcon_fgate;

    localparam int DW  = 32;
    localparam int ML  = 4;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rstn, enable, cnt_clr, vsync, pvalid, fmask;
    logic [DW-1:0] pdata;
    logic          fstart, ovs, opv, fdrop, err;
    logic [DW-1:0] opd;
    logic [CW-1:0] pass_cnt, drop_cnt;

    always #5 clk = ~clk;

    alp_fcon_fgate #(.DW(DW), .MASK_LAT(ML), .CW(CW)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_enable(enable), .i_cnt_clr(cnt_clr),
        .i_vsync(vsync), .i_pvalid(pvalid), .i_pdata(pdata),
        .o_fcon_fstart(fstart), .i_fcon_mask(fmask),
        .o_vsync(ovs), .o_pvalid(opv), .o_pdata(opd),
        .o_frame_drop(fdrop), .o_err(err),
        .o_pass_cnt(pass_cnt), .o_drop_cnt(drop_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state: decisions are tracked by absolute cycle number.
    int              cyc      = 0;
    int              m_sample = -1;   // cycle at which the pending mask is sampled
    logic            m_prev_vs = 1'b1;
    logic            m_en = 1'b0, m_gate = 1'b0, m_err = 1'b0;
    int              m_pass = 0, m_drop = 0;
    logic [DW+1:0]   m_hist[$];
    logic            e_fstart, e_fdrop, e_vs, e_pv;
    logic [DW-1:0]   e_pd;

    task automatic step(input logic vs, input logic pv, input logic [DW-1:0] pd,
                        input logic en, input logic mask, input logic clr, input logic rn);
        logic          rise, pending, drop;
        logic [DW+1:0] old;
        vsync = vs; pvalid = pv; pdata = pd; enable = en; fmask = mask;
        cnt_clr = clr; rstn = rn;
        if (!rn) begin
            m_prev_vs = 1'b1; m_sample = -1; m_en = 1'b0; m_gate = 1'b0;
            m_err = 1'b0; m_pass = 0; m_drop = 0;
            m_hist.delete();
            repeat (ML + 1) m_hist.push_back('0);
            e_fstart = 1'b0; e_fdrop = 1'b0; e_vs = 1'b0; e_pv = 1'b0; e_pd = '0;
        end else begin
            rise     = vs & ~m_prev_vs;
            pending  = (cyc <= m_sample);
            e_fstart = rise & ~pending;
            e_fdrop  = 1'b0;
            if (rise && !pending) begin
                m_sample = cyc + 1 + ML;
                m_en     = en;
            end
            if (rise && pending) m_err = 1'b1;
            else if (clr)        m_err = 1'b0;
            if (cyc == m_sample) begin
                drop    = m_en & mask;
                m_gate  = ~drop;
                e_fdrop = drop;
                if (drop && m_drop < SAT)       m_drop++;
                else if (!drop && m_pass < SAT) m_pass++;
            end
            if (clr) begin
                m_pass = 0;
                m_drop = 0;
            end
            m_hist.push_back({vs, pv, pd});
            old  = m_hist.pop_front();
            e_vs = old[DW+1] & m_gate;
            e_pv = old[DW] & m_gate;
            e_pd = m_gate ? old[DW-1:0] : '0;
            m_prev_vs = vs;
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("fstart",   fstart,   e_fstart);
        chk("fdrop",    fdrop,    e_fdrop);
        chk("o_vsync",  ovs,      e_vs);
        chk("o_pvalid", opv,      e_pv);
        chk("o_pdata",  opd,      e_pd);
        chk("o_err",    err,      m_err);
        chk("pass_cnt", pass_cnt, m_pass);
        chk("drop_cnt", drop_cnt, m_drop);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    // One frame: hi cycles of vsync, lo cycles of blanking, constant mask.
    task automatic frame(input int hi, input int lo, input logic en, input logic mask,
                         input logic clr_dec);
        for (int k = 0; k < hi + lo; k++)
            step(k < hi, (k < hi) ? 1'($urandom_range(0, 1)) : 1'b0, DW'($urandom),
                 en, mask, clr_dec && (k == 1 + ML), 1'b1);
    endtask

    initial begin
        rstn = 1'b0; enable = 1'b0; cnt_clr = 1'b0; vsync = 1'b0;
        pvalid = 1'b0; pdata = '0; fmask = 1'b0;

        repeat (3) step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(8);

        // Pass, drop, enable-off pass.
        frame(20, 8, 1'b1, 1'b0, 1'b0);
        chk("t1_pass", pass_cnt, 1);
        frame(20, 8, 1'b1, 1'b1, 1'b0);
        chk("t2_drop", drop_cnt, 1);
        frame(20, 8, 1'b0, 1'b1, 1'b0);
        chk("t3_pass", pass_cnt, 2);
        chk("t3_drop", drop_cnt, 1);

        // Second rise two cycles after the first, inside WAIT.
        step(1'b1, 1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        frame(10, 8, 1'b0, 1'b0, 1'b0);
        chk("t4_err", err, 1'b1);
        chk("t4_pass", pass_cnt, 3);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("t4_clr_err", err, 1'b0);

        // Reset in the middle of a frame with vsync held high.
        frame(5, 0, 1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b1, DW'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) step(1'b1, 1'b1, DW'($urandom), 1'b1, 1'b0, 1'b0, 1'b1);
        idle(8);
        frame(12, 8, 1'b1, 1'b0, 1'b0);
        chk("t5_pass", pass_cnt, 1);

        // Drop counter saturation, then a clear on the decision cycle.
        for (int f = 0; f < SAT + 3; f++) frame(8, 7, 1'b1, 1'b1, 1'b0);
        chk("t6_sat", drop_cnt, SAT);
        frame(8, 7, 1'b1, 1'b1, 1'b1);
        chk("t6_clr_drop", drop_cnt, 0);
        chk("t6_clr_pass", pass_cnt, 0);

        // Randomized frames, including short frames and occasional short blanking.
        for (int f = 0; f < 150; f++) begin
            int   hi, lo;
            logic en;
            hi = $urandom_range(1, 24);
            lo = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 14);
            en = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < hi + lo; k++)
                step(k < hi, (k < hi) ? 1'($urandom_range(0, 1)) : 1'b0, DW'($urandom),
                     en, 1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0), 1'b1);
        end
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
